// File: rtl/i2c_slave_fsm_if.sv
// i2c_slave_fsm_if: pin, FIFO and status signals between the I2C target and its surroundings.
interface i2c_slave_fsm_if;
    logic       enable_i;
    logic       i2c_scl_i;
    logic       i2c_sda_i;
    logic       sda_low_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_full_i;
    logic [7:0] tx_data_i;
    logic       tx_rd_o;
    logic       tx_empty_i;
    logic       rw_o;
    logic       busy_o;

    modport slave (
        input  enable_i, i2c_scl_i, i2c_sda_i, rx_full_i, tx_data_i, tx_empty_i,
        output sda_low_o, rx_data_o, rx_valid_o, tx_rd_o, rw_o, busy_o
    );

    modport master (
        output enable_i, i2c_scl_i, i2c_sda_i, rx_full_i, tx_data_i, tx_empty_i,
        input  sda_low_o, rx_data_o, rx_valid_o, tx_rd_o, rw_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: oversampled I2C target with 7-bit address match, RX push and TX pop.
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic            i2c_core_clk_i,
    input  logic            reset_ni,
    i2c_slave_fsm_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK} state_e;

    state_e     state_q, state_d;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_h_q, sda_h_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d, nack_q, nack_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_rd_q, tx_rd_d;
    logic       rw_q, rw_d;
    logic       busy_q;

    logic scl, sda, scl_rise, scl_fall, start, stop;
    logic [7:0] tx_byte;

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_h_q;
    assign scl_fall = ~scl & scl_h_q;
    assign start    = scl & ~sda & sda_h_q;
    assign stop     = scl & sda & ~sda_h_q;
    assign tx_byte  = bus.tx_empty_i ? 8'hFF : bus.tx_data_i;

    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // Synchronizers reset to the idle-bus level so no false START/STOP appears.
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= 8'h00;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_rd_q    <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.i2c_scl_i};
            sda_sync_q <= {sda_sync_q[0], bus.i2c_sda_i};
            scl_h_q    <= scl;
            sda_h_q    <= sda;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_rd_q    <= tx_rd_d;
            rw_q       <= rw_d;
            busy_q     <= state_d != IDLE;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        done_d     = done_q;
        nack_d     = nack_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_rd_d    = 1'b0;
        rw_d       = rw_q;
        if (!bus.enable_i) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            cnt_d     = 3'd7;
            done_d    = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            done_d = 1'b1;
                            rw_d   = sda;
                        end
                    end else if (scl_fall && done_q) begin
                        if (shift_q[7:1] == SLAVE_ADDR && (shift_q[0] || !bus.rx_full_i)) begin
                            state_d   = ADDR_ACK;
                            sda_low_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ADDR_ACK, TX_ACK: begin
                    // TX_ACK leaves on a NACK at the rise; reaching the fall means the master ACKed.
                    if (state_q == TX_ACK && scl_rise && sda) begin
                        state_d   = IDLE;
                        sda_low_d = 1'b0;
                    end else if (scl_fall) begin
                        cnt_d  = 3'd7;
                        done_d = 1'b0;
                        nack_d = 1'b0;
                        if (state_q == ADDR_ACK && !rw_q) begin
                            state_d   = RX_DATA;
                            sda_low_d = 1'b0;
                        end else begin
                            state_d   = TX_DATA;
                            shift_d   = tx_byte;
                            tx_rd_d   = !bus.tx_empty_i;
                            sda_low_d = ~tx_byte[7];
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise && !done_q) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 3'd1;
                        if (cnt_q == 3'd0) begin
                            done_d = 1'b1;
                            if (!bus.rx_full_i) begin
                                rx_data_d  = {shift_q[6:0], sda};
                                rx_valid_d = 1'b1;
                            end else begin
                                nack_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && done_q) begin
                        state_d   = RX_ACK;
                        sda_low_d = ~nack_q;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        state_d   = nack_q ? IDLE : RX_DATA;
                        cnt_d     = 3'd7;
                        done_d    = 1'b0;
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            state_d   = TX_ACK;
                            sda_low_d = 1'b0;
                        end else begin
                            cnt_d     = cnt_q - 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_low_o  = sda_low_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;
    assign bus.tx_rd_o    = tx_rd_q;
    assign bus.rw_o       = rw_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: bit-banged I2C master against the target, with RX/read-data scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_fsm;
    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    int         total = 0;
    int         bad = 0;
    int         tx_rd_n = 0;
    int         tx_ptr = 0;
    int         tx_end = 0;
    int         n0;
    logic [7:0] tx_mem [16];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic       ack;
    logic [7:0] d;

    i2c_slave_fsm_if bus();

    i2c_slave_fsm dut (
        .i2c_core_clk_i(clk),
        .reset_ni      (rst_n),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Open-drain line: either side can pull low.
    assign bus.i2c_scl_i  = m_scl;
    assign bus.i2c_sda_i  = m_sda & ~bus.sda_low_o;
    assign bus.tx_empty_i = tx_ptr == tx_end;
    assign bus.tx_data_i  = tx_mem[tx_ptr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_valid_o) begin
            chk("rx_expected", {31'd0, exp_rx.size() != 0}, 32'd1);
            if (exp_rx.size() != 0) chk("rx_data", {24'd0, bus.rx_data_o}, {24'd0, exp_rx.pop_front()});
        end
        if (bus.tx_rd_o) begin
            tx_rd_n <= tx_rd_n + 1;
            if (tx_ptr != tx_end) tx_ptr <= tx_ptr + 1;
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic bit_io(input logic b, output logic r);
        m_sda = b;    #Q;
        m_scl = 1'b1; #Q;
        r = bus.i2c_sda_i; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        a = !r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            v[i] = r;
        end
        bit_io(!mack, r);
    endtask

    initial begin
        bus.enable_i  = 1'b1;
        bus.rx_full_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_low", {31'd0, bus.sda_low_o}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.rx_data_o}, 32'h00);
        chk("rst_rx_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        chk("rst_tx_rd", {31'd0, bus.tx_rd_o}, 32'd0);
        chk("rst_rw", {31'd0, bus.rw_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        rst_n = 1'b1;
        #Q;

        // Write two bytes to our address.
        i2c_start();
        write_byte(8'hA0, ack);
        chk("w_addr_ack", {31'd0, ack}, 32'd1);
        chk("w_rw", {31'd0, bus.rw_o}, 32'd0);
        chk("w_busy", {31'd0, bus.busy_o}, 32'd1);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack);
        chk("w_b1_ack", {31'd0, ack}, 32'd1);
        exp_rx.push_back(8'hC3);
        write_byte(8'hC3, ack);
        chk("w_b2_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        #Q;
        chk("w_busy_stop", {31'd0, bus.busy_o}, 32'd0);
        chk("w_rx_drained", exp_rx.size(), 32'd0);

        // Foreign address is ignored until the next START.
        i2c_start();
        write_byte(8'hA2, ack);
        chk("x_addr_nack", {31'd0, ack}, 32'd0);
        chk("x_busy", {31'd0, bus.busy_o}, 32'd0);
        write_byte(8'h55, ack);
        chk("x_data_nack", {31'd0, ack}, 32'd0);
        chk("x_busy2", {31'd0, bus.busy_o}, 32'd0);
        i2c_stop();

        // Read two bytes, ACK then NACK.
        tx_mem[tx_end[3:0]] = 8'h5A; tx_end++;
        tx_mem[tx_end[3:0]] = 8'h81; tx_end++;
        exp_rd.push_back(8'h5A);
        exp_rd.push_back(8'h81);
        n0 = tx_rd_n;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("r_addr_ack", {31'd0, ack}, 32'd1);
        chk("r_rw", {31'd0, bus.rw_o}, 32'd1);
        read_byte(1'b1, d);
        chk("r_b1", {24'd0, d}, {24'd0, exp_rd.pop_front()});
        read_byte(1'b0, d);
        chk("r_b2", {24'd0, d}, {24'd0, exp_rd.pop_front()});
        chk("r_busy_nack", {31'd0, bus.busy_o}, 32'd0);
        chk("r_tx_rd_cnt", tx_rd_n - n0, 32'd2);
        i2c_stop();

        // Read from an empty TX FIFO.
        exp_rd.push_back(8'hFF);
        n0 = tx_rd_n;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("e_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b0, d);
        chk("e_byte", {24'd0, d}, {24'd0, exp_rd.pop_front()});
        chk("e_tx_rd_cnt", tx_rd_n - n0, 32'd0);
        i2c_stop();

        // RX FIFO fills before the second byte.
        i2c_start();
        write_byte(8'hA0, ack);
        chk("f_addr_ack", {31'd0, ack}, 32'd1);
        exp_rx.push_back(8'h12);
        write_byte(8'h12, ack);
        chk("f_b1_ack", {31'd0, ack}, 32'd1);
        bus.rx_full_i = 1'b1;
        write_byte(8'h34, ack);
        chk("f_b2_nack", {31'd0, ack}, 32'd0);
        chk("f_busy", {31'd0, bus.busy_o}, 32'd0);
        i2c_stop();
        bus.rx_full_i = 1'b0;
        chk("f_rx_drained", exp_rx.size(), 32'd0);

        // Write, repeated START, read.
        i2c_start();
        write_byte(8'hA0, ack);
        chk("rs_w_ack", {31'd0, ack}, 32'd1);
        chk("rs_rw0", {31'd0, bus.rw_o}, 32'd0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack);
        chk("rs_b_ack", {31'd0, ack}, 32'd1);
        tx_mem[tx_end[3:0]] = 8'h96; tx_end++;
        exp_rd.push_back(8'h96);
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rs_r_ack", {31'd0, ack}, 32'd1);
        chk("rs_rw1", {31'd0, bus.rw_o}, 32'd1);
        read_byte(1'b0, d);
        chk("rs_rd", {24'd0, d}, {24'd0, exp_rd.pop_front()});
        i2c_stop();
        #Q;
        chk("rs_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rs_rx_drained", exp_rx.size(), 32'd0);

        // enable_i drop mid-transfer.
        i2c_start();
        write_byte(8'hA0, ack);
        chk("en_ack", {31'd0, ack}, 32'd1);
        bus.enable_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("en_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("en_sda", {31'd0, bus.sda_low_o}, 32'd0);
        bus.enable_i = 1'b1;
        i2c_stop();

        // Asynchronous reset while driving a zero data bit.
        tx_mem[tx_end[3:0]] = 8'h00; tx_end++;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("ar_ack", {31'd0, ack}, 32'd1);
        bit_io(1'b1, ack);
        chk("ar_bit", {31'd0, ack}, 32'd0);
        chk("ar_sda_pre", {31'd0, bus.sda_low_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sda", {31'd0, bus.sda_low_o}, 32'd0);
        chk("ar_rw", {31'd0, bus.rw_o}, 32'd0);
        chk("ar_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("ar_rx_data", {24'd0, bus.rx_data_o}, 32'h00);
        #20;
        rst_n = 1'b1;
        i2c_stop();
        #Q;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
